com_uart: RTL and testbench

//  Serial-port end of the CPU COM interface: the peripheral behind COM_DATA/COM_STAT that the memory controller drives.

---
 rtl/com_uart_pkg.sv | 36 +++
 rtl/com_uart_rx_fifo.sv | 67 ++++++
 rtl/com_uart.sv | 215 +++++++++++++++++++++
 tb/tb_com_uart.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/com_uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | com_uart_pkg                                                       |
// | Shared FSM encodings, bit-timing constants and the divider helper  |
// | for the COM serial port.                                           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package com_uart_pkg;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   // Oversample ticks to mid-bit, and ticks per bit.
   localparam int unsigned c_tick_mid  = 8;
   localparam int unsigned c_bit_ticks = 16;

   // Clocks per 16x oversample tick, never below one.
   function automatic int unsigned osr_div(input int unsigned clk_freq, input int unsigned baud);
      int unsigned d;
      d = clk_freq / (baud * 16);
      return (d < 1) ? 1 : d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/com_uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | com_uart_rx_fifo                                                   |
// | Show-ahead receive FIFO. Head is 8'h00 when empty. A push into a   |
// | full FIFO is accepted only if a pop happens in the same cycle.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module com_uart_rx_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk50M,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head,
   output logic       empty,
   output logic       full
);
   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    mem_q [DEPTH];
   logic          w_do_push, w_do_pop;

   assign empty     = (count_q == '0);
   assign full      = (count_q == (AW+1)'(DEPTH));
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);
   assign head      = empty ? 8'h00 : mem_q[rd_ptr_q];

   // Pointer and occupancy update; pointers wrap naturally at the power-of-2 depth.
   always_comb begin
      wr_ptr_d = w_do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = w_do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (w_do_push & ~w_do_pop) begin
         count_d = count_q + 1'b1;
      end else if (w_do_pop & ~w_do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk50M) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage; contents are don't-care until written since head is masked when empty.
   always_ff @(posedge clk50M) begin
      if (!rst && w_do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/com_uart.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | com_uart                                                           |
// | 8N1 serial port behind COM_DATA/COM_STAT: transmitter, 2-FF        |
// | synchronised receiver feeding a show-ahead FIFO, ack edge pop.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module com_uart #(
   parameter int unsigned CLK_FREQ      = 50000000,
   parameter int unsigned BAUD          = 115200,
   parameter int unsigned RX_FIFO_DEPTH = 4
) (
   input  logic       clk50M,
   input  logic       rst,
   input  logic [7:0] com_data_out,
   input  logic       enable_com_write,
   output logic       com_write_ready,
   output logic [7:0] com_data_in,
   output logic       com_read_ready,
   input  logic       int_com_ack,
   output logic       rx_overrun,
   output logic       uart_txd,
   input  logic       uart_rxd
);
   import com_uart_pkg::*;

   localparam int unsigned OSR_DIV     = osr_div(CLK_FREQ, BAUD);
   localparam int          DIV_W       = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
   localparam logic [3:0]  c_mid_tick  = 4'(c_tick_mid - 1);
   localparam logic [3:0]  c_last_tick = 4'(c_bit_ticks - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             sync1_q, sync2_q, rx_prev_q, ack_prev_q, overrun_q, overrun_d;
   tx_state_e        tx_state_q, tx_state_d;
   logic [7:0]       tx_shift_q, tx_shift_d;
   logic [2:0]       tx_bit_q, tx_bit_d;
   logic [3:0]       tx_tcnt_q, tx_tcnt_d;
   logic             tx_first_q, tx_first_d, txd_q, txd_d;
   rx_state_e        rx_state_q, rx_state_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [3:0]       rx_tcnt_q, rx_tcnt_d;
   logic             w_tick, w_fall, w_push, w_pop, w_empty, w_full;
   logic [7:0]       w_head;

   assign w_tick          = (div_q == DIV_W'(OSR_DIV - 1));
   assign w_fall          = rx_prev_q & ~sync2_q;
   assign w_pop           = int_com_ack & ~ack_prev_q;
   assign uart_txd        = txd_q;
   assign com_write_ready = (tx_state_q == TX_IDLE);
   assign com_read_ready  = ~w_empty;
   assign com_data_in     = w_head;
   assign rx_overrun      = overrun_q;

   // Free-running oversample divider and sticky overrun flag.
   always_comb begin
      div_d     = w_tick ? '0 : div_q + 1'b1;
      overrun_d = overrun_q | (w_push & w_full & ~w_pop);
   end

   // Transmitter: a flagged first tick drives the start bit, then every 16 ticks is a boundary.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      tx_bit_d   = tx_bit_q;
      tx_tcnt_d  = tx_tcnt_q;
      tx_first_d = tx_first_q;
      txd_d      = txd_q;
      case (tx_state_q)
         TX_IDLE: if (enable_com_write) begin
            tx_shift_d = com_data_out;
            tx_first_d = 1'b1;
            tx_tcnt_d  = 4'd0;
            tx_state_d = TX_START;
         end
         TX_START: if (w_tick) begin
            if (tx_first_q) begin
               txd_d      = 1'b0;
               tx_first_d = 1'b0;
               tx_tcnt_d  = 4'd0;
            end else if (tx_tcnt_q == c_last_tick) begin
               txd_d      = tx_shift_q[0];
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = 3'd0;
               tx_tcnt_d  = 4'd0;
               tx_state_d = TX_DATA;
            end else begin
               tx_tcnt_d  = tx_tcnt_q + 4'd1;
            end
         end
         TX_DATA: if (w_tick) begin
            if (tx_tcnt_q == c_last_tick) begin
               tx_tcnt_d = 4'd0;
               if (tx_bit_q == 3'd7) begin
                  txd_d      = 1'b1;
                  tx_state_d = TX_STOP;
               end else begin
                  txd_d      = tx_shift_q[0];
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_bit_d   = tx_bit_q + 3'd1;
               end
            end else begin
               tx_tcnt_d = tx_tcnt_q + 4'd1;
            end
         end
         TX_STOP: if (w_tick) begin
            if (tx_tcnt_q == c_last_tick) begin
               tx_state_d = TX_IDLE;
            end else begin
               tx_tcnt_d  = tx_tcnt_q + 4'd1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // Receiver: validate start at mid-bit, then sample every 16 ticks; push on a good stop bit.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_shift_d = rx_shift_q;
      rx_bit_d   = rx_bit_q;
      rx_tcnt_d  = rx_tcnt_q;
      w_push     = 1'b0;
      case (rx_state_q)
         RX_IDLE: if (w_fall) begin
            rx_tcnt_d  = 4'd0;
            rx_state_d = RX_START;
         end
         RX_START: if (w_tick) begin
            if (rx_tcnt_q == c_mid_tick) begin
               rx_tcnt_d  = 4'd0;
               rx_bit_d   = 3'd0;
               rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_tcnt_d  = rx_tcnt_q + 4'd1;
            end
         end
         RX_DATA: if (w_tick) begin
            if (rx_tcnt_q == c_last_tick) begin
               rx_tcnt_d  = 4'd0;
               rx_shift_d = {sync2_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end
            end else begin
               rx_tcnt_d = rx_tcnt_q + 4'd1;
            end
         end
         RX_STOP: if (w_tick) begin
            if (rx_tcnt_q == c_last_tick) begin
               w_push     = sync2_q;
               rx_state_d = RX_IDLE;
            end else begin
               rx_tcnt_d  = rx_tcnt_q + 4'd1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // All top-level state with synchronous reset; the line synchroniser resets to idle-high.
   always_ff @(posedge clk50M) begin
      if (rst) begin
         div_q      <= '0;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         ack_prev_q <= 1'b0;
         overrun_q  <= 1'b0;
         tx_state_q <= TX_IDLE;
         tx_shift_q <= 8'h00;
         tx_bit_q   <= 3'd0;
         tx_tcnt_q  <= 4'd0;
         tx_first_q <= 1'b0;
         txd_q      <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_shift_q <= 8'h00;
         rx_bit_q   <= 3'd0;
         rx_tcnt_q  <= 4'd0;
      end else begin
         div_q      <= div_d;
         sync1_q    <= uart_rxd;
         sync2_q    <= sync1_q;
         rx_prev_q  <= sync2_q;
         ack_prev_q <= int_com_ack;
         overrun_q  <= overrun_d;
         tx_state_q <= tx_state_d;
         tx_shift_q <= tx_shift_d;
         tx_bit_q   <= tx_bit_d;
         tx_tcnt_q  <= tx_tcnt_d;
         tx_first_q <= tx_first_d;
         txd_q      <= txd_d;
         rx_state_q <= rx_state_d;
         rx_shift_q <= rx_shift_d;
         rx_bit_q   <= rx_bit_d;
         rx_tcnt_q  <= rx_tcnt_d;
      end
   end

   com_uart_rx_fifo #(
      .DEPTH(RX_FIFO_DEPTH)
   ) u_rx_fifo (
      .clk50M    (clk50M),
      .rst       (rst),
      .push      (w_push),
      .push_data (rx_shift_q),
      .pop       (w_pop),
      .head      (w_head),
      .empty     (w_empty),
      .full      (w_full)
   );

endmodule
`default_nettype wire

// File: tb/tb_com_uart.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_com_uart                                                        |
// | Directed and randomised checks of com_uart at 16 clocks per bit,   |
// | with a reference line decoder and a queue model of the RX FIFO.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_com_uart;
   localparam int unsigned CLK_FREQ = 1600000;
   localparam int unsigned BAUD     = 100000;

   logic       clk50M = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] com_data_out = 8'h00;
   logic       enable_com_write = 1'b0;
   logic       int_com_ack = 1'b0;
   logic       rxd_drv = 1'b1;
   logic       loopback = 1'b0;
   logic       uart_rxd;
   logic       com_write_ready, com_read_ready, rx_overrun, uart_txd;
   logic [7:0] com_data_in;

   int         passed = 0;
   int         total = 0;
   int         failed = 0;
   logic [7:0] mq[$];
   bit         movr;
   logic [7:0] vals [256];

   assign uart_rxd = loopback ? uart_txd : rxd_drv;

   always #5 clk50M = ~clk50M;

   com_uart #(
      .CLK_FREQ      (CLK_FREQ),
      .BAUD          (BAUD),
      .RX_FIFO_DEPTH (4)
   ) dut (
      .clk50M           (clk50M),
      .rst              (rst),
      .com_data_out     (com_data_out),
      .enable_com_write (enable_com_write),
      .com_write_ready  (com_write_ready),
      .com_data_in      (com_data_in),
      .com_read_ready   (com_read_ready),
      .int_com_ack      (int_com_ack),
      .rx_overrun       (rx_overrun),
      .uart_txd         (uart_txd),
      .uart_rxd         (uart_rxd)
   );

   task automatic check1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk50M);
   endtask

   task automatic do_reset();
      @(negedge clk50M);
      rst = 1'b1;
      int_com_ack = 1'b0;
      enable_com_write = 1'b0;
      rxd_drv = 1'b1;
      step(3);
      rst = 1'b0;
      step(2);
   endtask

   // Drive one frame onto the receive line, 16 clocks per bit, then 4 idle clocks.
   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      @(negedge clk50M);
      rxd_drv = 1'b0;
      step(16);
      for (int i = 0; i < 8; i++) begin
         rxd_drv = b[i];
         step(16);
      end
      rxd_drv = stop_bit;
      step(16);
      rxd_drv = 1'b1;
      step(4);
   endtask

   task automatic ack_pulse(input int hold);
      @(negedge clk50M);
      int_com_ack = 1'b1;
      step(hold);
      int_com_ack = 1'b0;
      step(2);
   endtask

   // One-cycle write strobe; returns on the negedge right after the latching edge.
   task automatic write_tx(input logic [7:0] b);
      @(negedge clk50M);
      com_data_out = b;
      enable_com_write = 1'b1;
      @(negedge clk50M);
      enable_com_write = 1'b0;
   endtask

   // Reference receiver on uart_txd: find the start bit, sample each bit at its middle.
   task automatic ref_rx(output logic [7:0] b, output logic ok);
      int n;
      n = 0;
      b = 8'h00;
      ok = 1'b1;
      @(negedge clk50M);
      while (uart_txd !== 1'b0 && n < 400) begin
         @(negedge clk50M);
         n++;
      end
      if (n >= 400) begin
         ok = 1'b0;
      end else begin
         step(8);
         if (uart_txd !== 1'b0) ok = 1'b0;
         for (int i = 0; i < 8; i++) begin
            step(16);
            b[i] = uart_txd;
         end
         step(16);
         if (uart_txd !== 1'b1) ok = 1'b0;
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
      $fatal(1, "watchdog");
   end

   initial begin
      int         j;
      int         n;
      logic [9:0] frame;
      logic [7:0] got;
      logic [7:0] tmp;
      logic       ok;

      // Reset held three cycles with an idle receive line.
      rst = 1'b1;
      step(3);
      check1("rst_txd", uart_txd, 1'b1);
      check1("rst_wready", com_write_ready, 1'b1);
      check1("rst_rready", com_read_ready, 1'b0);
      check8("rst_data_in", com_data_in, 8'h00);
      check1("rst_overrun", rx_overrun, 1'b0);
      rst = 1'b0;
      step(2);

      // Transmit 8'hA5 and check the first and last clock of every bit; a mid-frame strobe is ignored.
      frame = {1'b1, 8'hA5, 1'b0};
      write_tx(8'hA5);
      j = 0;
      check1("tx_wready_low", com_write_ready, 1'b0);
      check1("tx_idle_before_start", uart_txd, 1'b1);
      for (int k = 0; k < 10; k++) begin
         step(1 + 16*k - j);
         j = 1 + 16*k;
         check1($sformatf("tx_bit%0d_first", k), uart_txd, frame[k]);
         if (k == 4) begin
            com_data_out = 8'hFF;
            enable_com_write = 1'b1;
            step(1);
            enable_com_write = 1'b0;
            j++;
         end
         step(16*(k+1) - j);
         j = 16*(k+1);
         check1($sformatf("tx_bit%0d_last", k), uart_txd, frame[k]);
      end
      check1("tx_wready_in_stop", com_write_ready, 1'b0);
      step(1);
      check1("tx_wready_after_stop", com_write_ready, 1'b1);
      step(24);
      check1("tx_no_queued_frame", uart_txd, 1'b1);

      // Receive 8'h3C: ready appears 155 clocks after the start edge; a long ack pops once.
      fork
         send_rx(8'h3C, 1'b1);
         begin
            @(negedge clk50M);
            step(154);
            check1("rx_latency_before", com_read_ready, 1'b0);
            step(1);
            check1("rx_latency_at", com_read_ready, 1'b1);
            check8("rx_3c_data", com_data_in, 8'h3C);
         end
      join
      ack_pulse(3);
      check1("rx_pop_ready", com_read_ready, 1'b0);
      check8("rx_pop_data", com_data_in, 8'h00);

      // Short glitch and a framing error both leave the FIFO empty.
      @(negedge clk50M);
      rxd_drv = 1'b0;
      step(5);
      rxd_drv = 1'b1;
      step(40);
      check1("glitch_no_push", com_read_ready, 1'b0);
      send_rx(8'h55, 1'b0);
      step(10);
      check1("frame_err_no_push", com_read_ready, 1'b0);
      check1("frame_err_no_flag", rx_overrun, 1'b0);

      // Five bytes into a four-entry FIFO: the fifth is dropped and overrun sticks.
      for (int b = 1; b <= 5; b++) send_rx(8'(b), 1'b1);
      check1("ovf_flag", rx_overrun, 1'b1);
      for (int b = 1; b <= 4; b++) begin
         check8($sformatf("ovf_pop%0d", b), com_data_in, 8'(b));
         ack_pulse(3);
      end
      check1("ovf_drained", com_read_ready, 1'b0);
      check1("ovf_sticky", rx_overrun, 1'b1);

      // Full FIFO with an ack edge landing on the push of 8'h06.
      do_reset();
      check1("rst_clears_overrun", rx_overrun, 1'b0);
      for (int b = 0; b < 4; b++) send_rx(8'h0A + 8'(b), 1'b1);
      check8("full_head", com_data_in, 8'h0A);
      fork
         send_rx(8'h06, 1'b1);
         begin
            @(negedge clk50M);
            step(154);
            int_com_ack = 1'b1;
            step(3);
            int_com_ack = 1'b0;
         end
      join
      check1("simul_no_overrun", rx_overrun, 1'b0);
      check8("simul_head", com_data_in, 8'h0B);
      tmp = 8'h0B;
      for (int b = 0; b < 4; b++) begin
         check8($sformatf("simul_drain%0d", b), com_data_in, (b == 3) ? 8'h06 : tmp + 8'(b));
         ack_pulse(1);
      end
      check1("simul_empty", com_read_ready, 1'b0);

      // Random receive traffic and acks against a queue model of the FIFO.
      do_reset();
      mq.delete();
      movr = 1'b0;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(2, 0) != 0) begin
            tmp = 8'($urandom);
            send_rx(tmp, 1'b1);
            if (mq.size() < 4) mq.push_back(tmp);
            else movr = 1'b1;
         end else begin
            ack_pulse(int'($urandom_range(4, 1)));
            if (mq.size() > 0) void'(mq.pop_front());
         end
         check1($sformatf("rand%0d_ready", it), com_read_ready, mq.size() != 0);
         check8($sformatf("rand%0d_data", it), com_data_in, (mq.size() != 0) ? mq[0] : 8'h00);
         check1($sformatf("rand%0d_overrun", it), rx_overrun, movr);
      end

      // Loopback of all 256 byte values in shuffled order.
      do_reset();
      loopback = 1'b1;
      for (int i = 0; i < 256; i++) vals[i] = 8'(i);
      for (int i = 255; i > 0; i--) begin
         n = int'($urandom_range(i, 0));
         tmp = vals[i];
         vals[i] = vals[n];
         vals[n] = tmp;
      end
      for (int i = 0; i < 256; i++) begin
         fork
            write_tx(vals[i]);
            ref_rx(got, ok);
         join
         check1($sformatf("lb%0d_ref_frame", i), ok, 1'b1);
         check8($sformatf("lb%0d_ref_byte", i), got, vals[i]);
         n = 0;
         while (com_read_ready !== 1'b1 && n < 64) begin
            step(1);
            n++;
         end
         check8($sformatf("lb%0d_rx_byte", i), com_data_in, vals[i]);
         ack_pulse(1);
         check1($sformatf("lb%0d_popped", i), com_read_ready, 1'b0);
         n = 0;
         while (com_write_ready !== 1'b1 && n < 64) begin
            step(1);
            n++;
         end
      end
      loopback = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
